// File: rtl/serial_subtractor8_pkg.sv
// serial_subtractor8_pkg: shared FSM encoding and default width for the serial subtractor
package serial_subtractor8_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;
endpackage

// File: rtl/serial_subtractor8_fulladder.sv
// serial_subtractor8_fulladder: gate-level one-bit full adder cell
module serial_subtractor8_fulladder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);
  logic p;
  assign p      = a_i ^ b_i;
  assign sum_o  = p ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & p);
endmodule

// File: rtl/serial_subtractor8.sv
// serial_subtractor8: bit-serial a - b (LSB first) through one full adder with inverted b and carry seeded to 1
module serial_subtractor8
  import serial_subtractor8_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             ovf_o
);
  localparam int CW = $clog2(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, borrow_q, borrow_d, ovf_q, ovf_d;
  logic             s, co, last;
  serial_subtractor8_fulladder u_fa (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (carry_q),
    .sum_o (s),
    .cout_o(co)
  );
  assign last = cnt_q == CW'(WIDTH - 1);
  // Sum bits fill the minuend register from the top as its bits are consumed,
  // so after WIDTH shifts it holds the complete difference.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: if (start_i) begin
        a_d     = a_i;
        b_d     = ~b_i;
        carry_d = 1'b1;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d     = {s, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        carry_d = co;
        cnt_d   = last ? cnt_q : cnt_q + CW'(1);
        if (last) begin
          diff_d   = {s, a_q[WIDTH-1:1]};
          borrow_d = ~co;
          ovf_d    = carry_q ^ co;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end
  assign ready_o  = state_q == IDLE;
  assign done_o   = state_q == DONE;
  assign diff_o   = diff_q;
  assign borrow_o = borrow_q;
  assign ovf_o    = ovf_q;
endmodule

// File: tb/tb_serial_subtractor8.sv
// tb_serial_subtractor8: table, hand-written and random checks of the serial subtractor
module tb_serial_subtractor8;
  logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic [7:0] a_i = '0, b_i = '0, diff_o;
  logic       ready_o, done_o, borrow_o, ovf_o;
  int checks = 0, failures = 0, cyc = 0;
  int done_cyc, ready_cyc;
  typedef struct {
    logic [7:0] a, b, d;
    logic       bo, ov;
  } vec_t;
  vec_t tv[5];

  serial_subtractor8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .ready_o(ready_o), .done_o(done_o), .diff_o(diff_o),
    .borrow_o(borrow_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    int ud = int'(a) - int'(b);
    int sd = int'($signed(a)) - int'($signed(b));
    logic [7:0] d = 8'(ud);
    return {ud < 0, (sd > 127) || (sd < -128), d};
  endfunction

  // Enters and leaves #1 after a rising edge; issues one op as soon as ready.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [9:0] exp);
    int n = 0;
    while (!ready_o && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", {31'd0, ready_o}, 32'd1);
    start_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done_o && n < 20);
    done_cyc = cyc;
    chk("latency", n, 8);
    chk("diff", {24'd0, diff_o}, {24'd0, exp[7:0]});
    chk("borrow", {31'd0, borrow_o}, {31'd0, exp[9]});
    chk("ovf", {31'd0, ovf_o}, {31'd0, exp[8]});
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done_o}, 32'd0);
    chk("ready_back", {31'd0, ready_o}, 32'd1);
    ready_cyc = cyc;
  endtask

  initial begin
    int prev_ready, dones;
    logic [9:0] e;
    tv[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tv[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tv[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tv[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    tv[4] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_diff", {24'd0, diff_o}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_o}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      prev_ready = ready_cyc;
      run_op(tv[i].a, tv[i].b, {tv[i].bo, tv[i].ov, tv[i].d});
      if (i > 0) chk("b2b_gap", done_cyc - prev_ready, 9);
    end
    // Busy-time start pulses and operand changes must not disturb the op.
    start_i = 1'b1; a_i = 8'h5A; b_i = 8'h3C;
    @(posedge clk); #1;
    a_i = 8'hFF; b_i = 8'h11;
    dones = 0;
    for (int k = 1; k <= 12; k++) begin
      start_i = (k == 3) || (k == 8);
      @(posedge clk); #1;
      if (done_o) begin
        dones++;
        chk("busy_diff", {24'd0, diff_o}, 32'h1E);
        chk("busy_borrow", {31'd0, borrow_o}, 32'd0);
      end
    end
    start_i = 1'b0;
    chk("busy_dones", dones, 1);
    run_op(8'h7F, 8'hFF, 10'h380);
    // Asynchronous reset in the middle of an op.
    start_i = 1'b1; a_i = 8'h12; b_i = 8'h34;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd1);
    chk("mid_rst_done", {31'd0, done_o}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff_o}, 32'd0);
    chk("mid_rst_borrow", {31'd0, borrow_o}, 32'd0);
    chk("mid_rst_ovf", {31'd0, ovf_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    chk("mid_rst_nodone", dones, 0);
    run_op(8'h12, 8'h34, model(8'h12, 8'h34));
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra = 8'($urandom), rb = 8'($urandom);
      e = model(ra, rb);
      run_op(ra, rb, e);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
